// File: rtl/full_adder_bh.sv
// Registered WIDTH-bit ripple-carry adder with group propagate/generate outputs.
// Define FULL_ADDER_BH_OVF_EN to add the registered signed-overflow output ovf.
module full_adder_bh #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             grp_p,
    output logic             grp_g
`ifdef FULL_ADDER_BH_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] sum_w;
    logic             k_w;
    logic             kg_w;
    logic             prop_w;
    logic             p_i;
    logic             g_i;
`ifdef FULL_ADDER_BH_OVF_EN
    logic             k_prev_w;
`endif

    // kg_w is a second chain seeded with 0 so grp_g ignores cin.
    always_comb begin
        sum_w  = '0;
        k_w    = cin;
        kg_w   = 1'b0;
        prop_w = 1'b1;
        p_i    = 1'b0;
        g_i    = 1'b0;
`ifdef FULL_ADDER_BH_OVF_EN
        k_prev_w = cin;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            p_i      = a[i] ^ b[i];
            g_i      = a[i] & b[i];
            sum_w[i] = p_i ^ k_w;
`ifdef FULL_ADDER_BH_OVF_EN
            k_prev_w = k_w;
`endif
            k_w      = g_i | (k_w & p_i);
            kg_w     = g_i | (kg_w & p_i);
            prop_w   = prop_w & p_i;
        end
    end

    logic [WIDTH-1:0] s_d, s_q;
    logic             c_d, c_q;
    logic             grp_p_d, grp_p_q;
    logic             grp_g_d, grp_g_q;
    logic             out_valid_d, out_valid_q;
`ifdef FULL_ADDER_BH_OVF_EN
    logic             ovf_d, ovf_q;
`endif

    always_comb begin
        s_d         = s_q;
        c_d         = c_q;
        grp_p_d     = grp_p_q;
        grp_g_d     = grp_g_q;
        out_valid_d = in_valid;
`ifdef FULL_ADDER_BH_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (in_valid) begin
            s_d     = sum_w;
            c_d     = k_w;
            grp_p_d = prop_w;
            grp_g_d = kg_w;
`ifdef FULL_ADDER_BH_OVF_EN
            ovf_d   = k_w ^ k_prev_w;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            c_q         <= 1'b0;
            grp_p_q     <= 1'b0;
            grp_g_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FULL_ADDER_BH_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            s_q         <= s_d;
            c_q         <= c_d;
            grp_p_q     <= grp_p_d;
            grp_g_q     <= grp_g_d;
            out_valid_q <= out_valid_d;
`ifdef FULL_ADDER_BH_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign grp_p     = grp_p_q;
    assign grp_g     = grp_g_q;
    assign out_valid = out_valid_q;
`ifdef FULL_ADDER_BH_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_bh.sv
// Self-checking bench for full_adder_bh at WIDTH 1, 4 and 8 against an
// arithmetic reference model plus directed literal expectations.
module tb_full_adder_bh;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic       v1, a1, b1, ci1;
    logic       ov1, s1, c1, p1, g1;
    logic       v4, ci4;
    logic [3:0] a4, b4, s4;
    logic       ov4, c4, p4, g4;
    logic       v8, ci8;
    logic [7:0] a8, b8, s8;
    logic       ov8, c8, p8, g8;
`ifdef FULL_ADDER_BH_OVF_EN
    logic       f1, f4, f8;
`endif

    full_adder_bh #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(ci1),
        .out_valid(ov1), .s(s1), .c(c1), .grp_p(p1), .grp_g(g1)
`ifdef FULL_ADDER_BH_OVF_EN
        , .ovf(f1)
`endif
    );
    full_adder_bh #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(ci4),
        .out_valid(ov4), .s(s4), .c(c4), .grp_p(p4), .grp_g(g4)
`ifdef FULL_ADDER_BH_OVF_EN
        , .ovf(f4)
`endif
    );
    full_adder_bh #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(ci8),
        .out_valid(ov8), .s(s8), .c(c8), .grp_p(p8), .grp_g(g8)
`ifdef FULL_ADDER_BH_OVF_EN
        , .ovf(f8)
`endif
    );

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        p;
        logic        g;
        logic        o;
    } res_t;

    // Reference: plain integer arithmetic on w-bit unsigned/signed operands.
    function automatic res_t ref_add(int w, logic [63:0] a, logic [63:0] b,
                                     logic cin);
        res_t        r;
        longint      mask, ua, ub, full, sa, sb, ss, lim;
        mask   = (longint'(1) << w) - 1;
        ua     = longint'(a) & mask;
        ub     = longint'(b) & mask;
        full   = ua + ub + longint'(cin);
        r.s    = 64'(full & mask);
        r.c    = (full >> w) != 0;
        r.g    = ((ua + ub) >> w) != 0;
        r.p    = ((ua ^ ub) & mask) == mask;
        lim    = longint'(1) << (w - 1);
        sa     = (ua >= lim) ? ua - (longint'(1) << w) : ua;
        sb     = (ub >= lim) ? ub - (longint'(1) << w) : ub;
        ss     = sa + sb + longint'(cin);
        r.o    = (ss > lim - 1) || (ss < -lim);
        return r;
    endfunction

    res_t e1, e4, e8;
    logic ev1, ev4, ev8, ecin8;

    always @(posedge clk) begin
        ev1 <= rst ? 1'b0 : v1;
        ev4 <= rst ? 1'b0 : v4;
        ev8 <= rst ? 1'b0 : v8;
        if (rst) begin
            e1 <= '0;
            e4 <= '0;
            e8 <= '0;
            ecin8 <= 1'b0;
        end else begin
            if (v1) e1 <= ref_add(1, 64'(a1), 64'(b1), ci1);
            if (v4) e4 <= ref_add(4, 64'(a4), 64'(b4), ci4);
            if (v8) begin
                e8    <= ref_add(8, 64'(a8), 64'(b8), ci8);
                ecin8 <= ci8;
            end
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("w1.valid", 64'(ov1), 64'(ev1));
            check("w1.s", 64'(s1), e1.s);
            check("w1.c", 64'(c1), 64'(e1.c));
            check("w1.p", 64'(p1), 64'(e1.p));
            check("w1.g", 64'(g1), 64'(e1.g));
            check("w4.valid", 64'(ov4), 64'(ev4));
            check("w4.s", 64'(s4), e4.s);
            check("w4.c", 64'(c4), 64'(e4.c));
            check("w4.p", 64'(p4), 64'(e4.p));
            check("w4.g", 64'(g4), 64'(e4.g));
            check("w8.valid", 64'(ov8), 64'(ev8));
            check("w8.s", 64'(s8), e8.s);
            check("w8.c", 64'(c8), 64'(e8.c));
            check("w8.p", 64'(p8), 64'(e8.p));
            check("w8.g", 64'(g8), 64'(e8.g));
`ifdef FULL_ADDER_BH_OVF_EN
            check("w1.ovf", 64'(f1), 64'(e1.o));
            check("w4.ovf", 64'(f4), 64'(e4.o));
            check("w8.ovf", 64'(f8), 64'(e8.o));
`endif
            if (ev8)
                check("w8.inv", 64'(c8), 64'(g8 | (p8 & ecin8)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic exp_s1 [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_c1 [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst = 1'b1;
        v1 = 0; a1 = 0; b1 = 0; ci1 = 0;
        v4 = 0; a4 = 0; b4 = 0; ci4 = 0;
        v8 = 0; a8 = 0; b8 = 0; ci8 = 0;
        tick();
        chk_en = 1'b1;
        check("rst.s8", 64'(s8), 64'h0);
        check("rst.valid8", 64'(ov8), 64'h0);
        check("rst.c4", 64'(c4), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v1 = 1'b1;
            {a1, b1, ci1} = 3'(i);
            tick();
            check($sformatf("exh%0d.s", i), 64'(s1), 64'(exp_s1[i]));
            check($sformatf("exh%0d.c", i), 64'(c1), 64'(exp_c1[i]));
            check($sformatf("exh%0d.v", i), 64'(ov1), 64'h1);
        end

        @(negedge clk);
        rst = 1'b1; v1 = 1; a1 = 1; b1 = 1; ci1 = 1;
        tick();
        check("rst_pri.s", 64'(s1), 64'h0);
        check("rst_pri.c", 64'(c1), 64'h0);
        check("rst_pri.v", 64'(ov1), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_rel.s", 64'(s1), 64'h1);
        check("rst_rel.c", 64'(c1), 64'h1);

        @(negedge clk);
        v1 = 1; a1 = 1; b1 = 0; ci1 = 0;
        tick();
        check("load.s", 64'(s1), 64'h1);
        @(negedge clk);
        v1 = 0; a1 = 1'bx; b1 = 1'bx; ci1 = 1'bx;
        tick();
        check("hold.s", 64'(s1), 64'h1);
        check("hold.c", 64'(c1), 64'h0);
        check("hold.v", 64'(ov1), 64'h0);
        @(negedge clk);
        a1 = 0; b1 = 0; ci1 = 0;

        @(negedge clk);
        v4 = 1; a4 = 4'hF; b4 = 4'h0; ci4 = 1;
        tick();
        check("w4a.s", 64'(s4), 64'h0);
        check("w4a.c", 64'(c4), 64'h1);
        check("w4a.p", 64'(p4), 64'h1);
        check("w4a.g", 64'(g4), 64'h0);
        @(negedge clk);
        a4 = 4'h8; b4 = 4'h8; ci4 = 0;
        tick();
        check("w4b.s", 64'(s4), 64'h0);
        check("w4b.c", 64'(c4), 64'h1);
        check("w4b.g", 64'(g4), 64'h1);
        @(negedge clk);
        a4 = 4'h7; b4 = 4'h1; ci4 = 0;
        tick();
        check("w4c.s", 64'(s4), 64'h8);
        check("w4c.c", 64'(c4), 64'h0);
`ifdef FULL_ADDER_BH_OVF_EN
        check("w4c.ovf", 64'(f4), 64'h1);
`endif
        @(negedge clk);
        a4 = 4'hF; b4 = 4'h1; ci4 = 0;
        tick();
        check("w4d.c", 64'(c4), 64'h1);
`ifdef FULL_ADDER_BH_OVF_EN
        check("w4d.ovf", 64'(f4), 64'h0);
`endif

        @(negedge clk);
        v8 = 1; a8 = 8'h5A; b8 = 8'hA5; ci8 = 1;
        tick();
        check("w8inv.s", 64'(s8), 64'h0);
        check("w8inv.c", 64'(c8), 64'h1);
        check("w8inv.p", 64'(p8), 64'h1);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1;
        tick();
        check("w8ones.s", 64'(s8), 64'hFF);
        check("w8ones.c", 64'(c8), 64'h1);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            v8  = 1'($urandom_range(0, 1));
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            ci8 = 1'($urandom);
            v4  = 1'($urandom_range(0, 1));
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            ci4 = 1'($urandom);
            v1  = 1'($urandom_range(0, 1));
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            ci1 = 1'($urandom);
        end
        @(negedge clk);
        v1 = 0; v4 = 0; v8 = 0;
        repeat (3) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
